// File: rtl/p1_dec_shift.sv
// -----------------------------------------------------------------------------
// p1_dec_shift
//
// Purpose:
//    Decode-stage shift reference block. It shifts one constant operand
//    (A_VALUE) by a shared 3-bit amount through three parallel shifters:
//    left logical, left arithmetic and right arithmetic. Each shifter has
//    its own registered result. A one-cycle valid pulse marks every edge
//    at which a new result was captured.
//
// Ports:
//    clk       in   1      rising-edge clock for all state
//    rst       in   1      synchronous active-high reset (beats en)
//    in        in   3      shift amount 0..7 (5..7 all saturate)
//    en        in   1      sample strobe; when low the result registers hold
//    out_lls   out  WIDTH  registered A << in
//    out_las   out  WIDTH  registered A <<< in (same bits as out_lls)
//    out_ras   out  WIDTH  registered A >>> in (sign-filling)
//    out_valid out  1      high for one cycle after an edge with en=1
// -----------------------------------------------------------------------------
module p1_dec_shift #(
   parameter int               WIDTH   = 5,
   parameter logic [WIDTH-1:0] A_VALUE = 5'b10100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       in,
   input  logic             en,
   output logic [WIDTH-1:0] out_lls,
   output logic [WIDTH-1:0] out_las,
   output logic [WIDTH-1:0] out_ras,
   output logic             out_valid
);

   // Logical left shift. Amounts at or beyond WIDTH push every bit out.
   function automatic logic [WIDTH-1:0] shl_f(input logic [WIDTH-1:0] a,
                                              input logic [2:0]       amt);
      logic [WIDTH-1:0] r;
      if (int'(amt) >= WIDTH) begin
         r = {WIDTH{1'b0}};
      end else begin
         r = a << amt;
      end
      return r;
   endfunction

   // Arithmetic right shift. Amounts at or beyond WIDTH leave only copies
   // of the sign bit, so they are handled explicitly.
   function automatic logic [WIDTH-1:0] sra_f(input logic [WIDTH-1:0] a,
                                              input logic [2:0]       amt);
      logic [WIDTH-1:0] r;
      if (int'(amt) >= WIDTH) begin
         r = {WIDTH{a[WIDTH-1]}};
      end else begin
         r = WIDTH'($signed(a) >>> amt);
      end
      return r;
   endfunction

   logic [WIDTH-1:0] lls_r;
   logic [WIDTH-1:0] las_r;
   logic [WIDTH-1:0] ras_r;
   logic             valid_r;

   logic [WIDTH-1:0] lls_s;
   logic [WIDTH-1:0] las_s;
   logic [WIDTH-1:0] ras_s;
   logic             valid_s;

   // Next-state selection: sample fresh results from the constant operand
   // when enabled, otherwise hold. The original A is always the source, so
   // nothing accumulates across cycles.
   always_comb begin
      lls_s   = lls_r;
      las_s   = las_r;
      ras_s   = ras_r;
      valid_s = 1'b0;
      if (en) begin
         lls_s   = shl_f(A_VALUE, in);
         // Left arithmetic shift ignores the sign, so it matches the logical one.
         las_s   = shl_f(A_VALUE, in);
         ras_s   = sra_f(A_VALUE, in);
         valid_s = 1'b1;
      end else begin
         lls_s   = lls_r;
         las_s   = las_r;
         ras_s   = ras_r;
         valid_s = 1'b0;
      end
   end

   // Result and valid registers with synchronous reset taking priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         lls_r   <= {WIDTH{1'b0}};
         las_r   <= {WIDTH{1'b0}};
         ras_r   <= {WIDTH{1'b0}};
         valid_r <= 1'b0;
      end else begin
         lls_r   <= lls_s;
         las_r   <= las_s;
         ras_r   <= ras_s;
         valid_r <= valid_s;
      end
   end

   assign out_lls   = lls_r;
   assign out_las   = las_r;
   assign out_ras   = ras_r;
   assign out_valid = valid_r;

endmodule

// File: tb/tb_p1_dec_shift.sv
// -----------------------------------------------------------------------------
// tb_p1_dec_shift
//
// Directed bench for p1_dec_shift with A = 5'b10100. The driver applies one
// vector per clock and pushes the hand-computed register contents expected
// after that edge into a queue; a monitor process pops one entry per edge
// (1 time unit after it) and compares all four outputs.
// -----------------------------------------------------------------------------
module tb_p1_dec_shift;

   typedef struct {
      string      name;
      logic [4:0] lls;
      logic [4:0] las;
      logic [4:0] ras;
      logic       valid;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [2:0] in;
   logic       en;
   logic [4:0] out_lls;
   logic [4:0] out_las;
   logic [4:0] out_ras;
   logic       out_valid;

   exp_t exp_q[$];
   int   n_checks;
   int   n_pass;
   bit   drive_done;

   p1_dec_shift #(
      .WIDTH  (5),
      .A_VALUE(5'b10100)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in       (in),
      .en       (en),
      .out_lls  (out_lls),
      .out_las  (out_las),
      .out_ras  (out_ras),
      .out_valid(out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld,
                      input logic [4:0] got, input logic [4:0] want);
      n_checks = n_checks + 1;
      if (got === want) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s.%s: got %b expected %b", nm, fld, got, want);
      end
   endtask

   // One vector: drive inputs, let the edge happen, record what it should leave.
   task automatic step(input string nm, input logic r, input logic e,
                       input logic [2:0] amt, input logic [4:0] l,
                       input logic [4:0] la, input logic [4:0] ra,
                       input logic v);
      exp_t x;
      rst = r;
      en  = e;
      in  = amt;
      @(posedge clk);
      x.name  = nm;
      x.lls   = l;
      x.las   = la;
      x.ras   = ra;
      x.valid = v;
      exp_q.push_back(x);
      @(negedge clk);
   endtask

   // Monitor: one expected entry per edge, compared just after the edge.
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         chk(x.name, "lls",   out_lls, x.lls);
         chk(x.name, "las",   out_las, x.las);
         chk(x.name, "ras",   out_ras, x.ras);
         chk(x.name, "valid", {4'b0000, out_valid}, {4'b0000, x.valid});
      end
   end

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      drive_done = 1'b0;
      rst = 1'b1;
      en  = 1'b1;
      in  = 3'd3;

      //    name           rst   en    in    lls        las        ras        valid
      step("reset0",      1'b1, 1'b1, 3'd3, 5'b00000, 5'b00000, 5'b00000, 1'b0);
      step("reset1",      1'b1, 1'b1, 3'd3, 5'b00000, 5'b00000, 5'b00000, 1'b0);
      step("idle_rst",    1'b0, 1'b0, 3'd3, 5'b00000, 5'b00000, 5'b00000, 1'b0);
      step("sh1",         1'b0, 1'b1, 3'd1, 5'b01000, 5'b01000, 5'b11010, 1'b1);
      step("sh2",         1'b0, 1'b1, 3'd2, 5'b10000, 5'b10000, 5'b11101, 1'b1);
      step("sh3",         1'b0, 1'b1, 3'd3, 5'b00000, 5'b00000, 5'b11110, 1'b1);
      step("sh4",         1'b0, 1'b1, 3'd4, 5'b00000, 5'b00000, 5'b11111, 1'b1);
      step("sh5",         1'b0, 1'b1, 3'd5, 5'b00000, 5'b00000, 5'b11111, 1'b1);
      step("sh0",         1'b0, 1'b1, 3'd0, 5'b10100, 5'b10100, 5'b10100, 1'b1);
      step("sh6",         1'b0, 1'b1, 3'd6, 5'b00000, 5'b00000, 5'b11111, 1'b1);
      step("sh7",         1'b0, 1'b1, 3'd7, 5'b00000, 5'b00000, 5'b11111, 1'b1);
      step("hold_load",   1'b0, 1'b1, 3'd2, 5'b10000, 5'b10000, 5'b11101, 1'b1);
      step("hold0",       1'b0, 1'b0, 3'd4, 5'b10000, 5'b10000, 5'b11101, 1'b0);
      step("hold1",       1'b0, 1'b0, 3'd4, 5'b10000, 5'b10000, 5'b11101, 1'b0);
      step("hold2",       1'b0, 1'b0, 3'd4, 5'b10000, 5'b10000, 5'b11101, 1'b0);
      step("mid_pre",     1'b0, 1'b1, 3'd1, 5'b01000, 5'b01000, 5'b11010, 1'b1);
      step("mid_rst",     1'b1, 1'b1, 3'd1, 5'b00000, 5'b00000, 5'b00000, 1'b0);
      step("mid_post",    1'b0, 1'b1, 3'd1, 5'b01000, 5'b01000, 5'b11010, 1'b1);
      step("after_post",  1'b0, 1'b1, 3'd2, 5'b10000, 5'b10000, 5'b11101, 1'b1);

      en = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_checks = n_checks + 1;
      if (exp_q.size() == 0) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
      end
      drive_done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #100000;
      if (!drive_done) begin
         $display("FAIL timeout: got no completion expected completion");
         $fatal(1, "time limit");
      end
   end

endmodule

// File: doc/p1_dec_shift.md
Name: p1_dec_shift

Overview:
- Registered shift unit that applies three fixed-operand shifters to one 5-bit constant operand A in parallel: left logical (LLS), left arithmetic (LAS) and right arithmetic (RAS).
- The 3-bit shift amount and the enable are shared by all three shifters; each shifter drives its own registered output.
- Used as a decode-stage shift reference block for bring-up and self-checking of shift semantics.

Parameters:
- A_VALUE, 5'b10100, constant 5-bit operand, treated as unsigned for LLS and signed (two's complement) for LAS/RAS.
- WIDTH, 5, operand/result width; only 5 is required to be supported.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in, input, 3, shift amount 0..7.
- en, input, 1, enable/sample strobe.
- out_lls, output, 5, registered result of A << in (logical).
- out_las, output, 5, signed, registered result of A <<< in.
- out_ras, output, 5, signed, registered result of A >>> in (sign-filling).
- out_valid, output, 1, high for one cycle after a cycle in which en was sampled high.

Behaviour:
- Everything is synchronous to the rising edge of clk; there are no combinational paths from inputs to outputs.
- Reset: when rst=1 at an edge, out_lls, out_las, out_ras and out_valid all become 0. rst takes priority over en.
- Latency is 1 cycle: with en=1 at edge N, all three outputs show results for the in value sampled at edge N, immediately after that edge.
- With en=0 at an edge (and rst=0):
  - the three result registers hold their previous values;
  - out_valid becomes 0.
- LLS: vacated LSBs fill with 0; bits shifted past the MSB are discarded. For in >= 5 the result is 5'b00000.
- LAS: bit-identical to LLS (the sign is not preserved; overflow is ignored).
- RAS: vacated MSBs fill with A[4].
  - For in >= 5 the result is 5'b11111 when A[4]=1, and 5'b00000 when A[4]=0.
- in=0 gives A unchanged on all three outputs.
- Results depend only on in and A_VALUE. There is no accumulation: each enabled cycle shifts the original A, never the previous output.
- in values 6 and 7 are legal and saturate exactly like in=5.
- Back-to-back en=1 cycles with changing in: each edge's result reflects that edge's in; no bubbles.
- Reset asserted mid-stream: outputs are 0 after the reset edge. The first en=1 edge after rst deasserts produces a normal result.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, in=3'b011 -> all outputs 5'b00000 and out_valid=0 after each reset edge.
- LLS/LAS sweep, en=1, in=1,2,3,4,5 on consecutive edges -> out_lls and out_las = 01000, 10000, 00000, 00000, 00000, each one cycle after its in; out_valid=1 throughout.
- RAS sweep, en=1, in=1,2,3,4,5 -> out_ras = 11010, 11101, 11110, 11111, 11111.
- Zero and saturating amounts:
  - in=0, en=1 -> all outputs 10100;
  - in=7, en=1 -> out_lls=out_las=00000, out_ras=11111.
- Hold: set in=2 with en=1 (out_lls=10000), then en=0 with in=4 for 3 cycles -> outputs stay 10000/10000/11101 and out_valid=0.
- Reset mid-stream: in=1, en=1, then assert rst for 1 cycle while en=1 -> outputs 00000. The next edge with rst=0, en=1, in=1 -> out_lls=01000, out_ras=11010.
